// File: rtl/rom_arbiter_pkg.sv
// Shared header for the ROM arbiter: FSM state encoding, port indices and counter sizing.
// No logic of its own; imported by rom_arbiter.
// Port index constants double as the value stored in the last-grant and owner registers.
package rom_arbiter_pkg;

  // Arbiter FSM states: accepting requests, waiting on memory, presenting a response.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Requester port indices.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Latency counter width; memory latency ranges over 1..7.
  localparam int CNT_W = 3;

endpackage

// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of a shared read-only memory, one read outstanding.
// Latency: request cycle N -> gnt at N+1, valid at N+2+MEM_LATENCY; one read per MEM_LATENCY+3 cycles.
// Backpressure: requesters hold req until their valid pulse; requests are ignored outside IDLE.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int MEM_ADDR    = 4,
  parameter int MEM_EXTRA   = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req0,
  input  logic                          req1,
  input  logic [MEM_ADDR:0]             addr0,
  input  logic [MEM_ADDR:0]             addr1,
  input  logic [MEM_EXTRA-1:0]          extra0,
  input  logic [MEM_EXTRA-1:0]          extra1,
  output logic                          gnt0,
  output logic                          gnt1,
  output logic                          valid0,
  output logic                          valid1,
  output logic [(2**MEM_EXTRA)*8-1:0]   data0,
  output logic [(2**MEM_EXTRA)*8-1:0]   data1,
  output logic                          error0,
  output logic                          error1,
  output logic [MEM_ADDR:0]             mem_addr,
  output logic [MEM_EXTRA-1:0]          mem_extra,
  input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
  input  logic                          mem_error
);

  localparam int                DATA_W = (2**MEM_EXTRA)*8;
  localparam logic [CNT_W-1:0]  LAT    = CNT_W'(MEM_LATENCY);

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  valid0_q, valid0_d, valid1_q, valid1_d;
  logic [DATA_W-1:0]     data0_q, data0_d, data1_q, data1_d;
  logic                  error0_q, error0_d, error1_q, error1_d;
  logic [MEM_ADDR:0]     mem_addr_q, mem_addr_d;
  logic [MEM_EXTRA-1:0]  mem_extra_q, mem_extra_d;

  logic any_req;
  logic win;
  logic capture;

  // Round robin: a lone requester wins; on contention the port not granted last time wins.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    else if (r1)  return PORT1;
    else          return PORT0;
  endfunction

  assign any_req = req0 | req1;
  assign win     = rr_pick(req0, req1, last_q);
  // The counter starts at MEM_LATENCY in the address cycle, so it reaches zero in the
  // cycle where the memory's data is valid; that is the edge we capture on.
  assign capture = (state_q == ST_WAIT) && (cnt_q == '0);

  // State and datapath registers; reset returns everything to zero with port 1 as last winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= PORT1;
      owner_q     <= PORT0;
      cnt_q       <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      valid0_q    <= 1'b0;
      valid1_q    <= 1'b0;
      data0_q     <= '0;
      data1_q     <= '0;
      error0_q    <= 1'b0;
      error1_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_extra_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      valid0_q    <= valid0_d;
      valid1_q    <= valid1_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      error0_q    <= error0_d;
      error1_q    <= error1_d;
      mem_addr_q  <= mem_addr_d;
      mem_extra_q <= mem_extra_d;
    end
  end

  // Next-state: accept in IDLE, leave WAIT on capture, RESP always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_d = ST_WAIT;
      ST_WAIT: if (capture) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values: grant and memory address on acceptance, result on capture.
  always_comb begin
    last_d      = last_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    valid0_d    = 1'b0;
    valid1_d    = 1'b0;
    data0_d     = data0_q;
    data1_d     = data1_q;
    error0_d    = error0_q;
    error1_d    = error1_q;
    mem_addr_d  = mem_addr_q;
    mem_extra_d = mem_extra_q;
    if ((state_q == ST_IDLE) && any_req) begin
      owner_d     = win;
      last_d      = win;
      gnt0_d      = (win == PORT0);
      gnt1_d      = (win == PORT1);
      cnt_d       = LAT;
      mem_addr_d  = (win == PORT1) ? addr1  : addr0;
      mem_extra_d = (win == PORT1) ? extra1 : extra0;
    end
    if (state_q == ST_WAIT) begin
      if (!capture) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else if (owner_q == PORT1) begin
        valid1_d = 1'b1;
        data1_d  = mem_data;
        error1_d = mem_error;
      end else begin
        valid0_d = 1'b1;
        data0_d  = mem_data;
        error0_d = mem_error;
      end
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign valid0    = valid0_q;
  assign valid1    = valid1_q;
  assign data0     = data0_q;
  assign data1     = data1_q;
  assign error0    = error0_q;
  assign error1    = error1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_extra = mem_extra_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter against a one-cycle-latency ROM model.
// ROM byte k = k ^ 0x29 (so byte 3 = 0x2A); addresses above 23 flag an error.
// Inputs change 1 ns after each rising edge; outputs are checked at the same point.
module tb_rom_arbiter;

  localparam int         MA     = 4;
  localparam int         ME     = 4;
  localparam int         DW     = (2**ME)*8;
  localparam logic [4:0] ROM_UB = 5'd23;

  logic            clk;
  logic            reset;
  logic            req0, req1;
  logic [MA:0]     addr0, addr1;
  logic [ME-1:0]   extra0, extra1;
  logic            gnt0, gnt1, valid0, valid1;
  logic [DW-1:0]   data0, data1;
  logic            error0, error1;
  logic [MA:0]     mem_addr;
  logic [ME-1:0]   mem_extra;
  logic [DW-1:0]   mem_data;
  logic            mem_error;

  logic [7:0] rom [32];

  int n_cmp = 0;
  int n_err = 0;

  rom_arbiter #(.MEM_ADDR(MA), .MEM_EXTRA(ME), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .extra0(extra0), .extra1(extra1),
    .gnt0(gnt0), .gnt1(gnt1),
    .valid0(valid0), .valid1(valid1),
    .data0(data0), .data1(data1),
    .error0(error0), .error1(error1),
    .mem_addr(mem_addr), .mem_extra(mem_extra),
    .mem_data(mem_data), .mem_error(mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 32; k++) rom[k] = 8'(k) ^ 8'h29;
    mem_data  = '0;
    mem_error = 1'b0;
  end

  // Synchronous ROM: data for the sampled address appears one cycle later.
  always @(posedge clk) begin
    if (mem_addr > ROM_UB) begin
      mem_error <= 1'b1;
      mem_data  <= '0;
    end else begin
      mem_error <= 1'b0;
      for (int i = 0; i < 16; i++) mem_data[i*8 +: 8] <= rom[mem_addr + 5'(i)];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; extra0 = '0; extra1 = '0;
    tick(); tick();

    // Reset state
    chk("rst_gnt",   {gnt0, gnt1},     2'b00);
    chk("rst_valid", {valid0, valid1}, 2'b00);
    chk("rst_data0", data0, '0);
    chk("rst_data1", data1, '0);
    chk("rst_err",   {error0, error1}, 2'b00);
    chk("rst_maddr", mem_addr, '0);
    chk("rst_mext",  mem_extra, '0);

    // Single read on port 0: addr 3 -> gnt at 1, valid at 3, byte 0x2A
    reset = 1'b0;
    req0 = 1'b1; addr0 = 5'd3; extra0 = 4'd0;
    tick();
    chk("r0_gnt0",   gnt0, 1'b1);
    chk("r0_gnt1",   gnt1, 1'b0);
    chk("r0_maddr",  mem_addr, 5'd3);
    chk("r0_mext",   mem_extra, 4'd0);
    tick();
    chk("r0_wait",   {gnt0, valid0}, 2'b00);
    tick();
    chk("r0_valid0", valid0, 1'b1);
    chk("r0_valid1", valid1, 1'b0);
    chk("r0_byte0",  data0[7:0], 8'h2A);
    chk("r0_byte1",  data0[15:8], 8'h2D);
    chk("r0_err",    error0, 1'b0);
    req0 = 1'b0;
    tick();
    chk("r0_vdone",  valid0, 1'b0);
    chk("r0_hold",   mem_addr, 5'd3);

    // Out-of-range read on port 1: error passes through, port 0 result untouched
    req1 = 1'b1; addr1 = 5'd30; extra1 = 4'd5;
    tick();
    chk("oob_gnt1",  {gnt0, gnt1}, 2'b01);
    chk("oob_maddr", mem_addr, 5'd30);
    chk("oob_mext",  mem_extra, 4'd5);
    tick();
    tick();
    chk("oob_valid", {valid0, valid1}, 2'b01);
    chk("oob_err1",  error1, 1'b1);
    chk("oob_data1", data1, '0);
    chk("oob_d0",    data0[7:0], 8'h2A);
    chk("oob_e0",    error0, 1'b0);
    req1 = 1'b0;
    tick();

    // Both ports requesting continuously from reset release: grants 0,1,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 5'd5; addr1 = 5'd8;
    for (int c = 1; c <= 16; c++) begin
      logic [3:0] exp_v;
      tick();
      exp_v = {(c % 8) == 1, (c % 8) == 5, (c % 8) == 3, (c % 8) == 7};
      chk($sformatf("rr_c%0d", c), {gnt0, gnt1, valid0, valid1}, exp_v);
      if (c == 3) chk("rr_d0", data0[7:0], 8'h2C);
      if (c == 7) chk("rr_d1", data1[7:0], 8'h21);
      if (c == 16) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end

    // Reset during WAIT aborts the read; next request proceeds normally
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; addr0 = 5'd3; extra0 = 4'd1;
    tick();
    chk("ab_gnt0", gnt0, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    chk("ab_valid", {valid0, valid1}, 2'b00);
    chk("ab_gnt",   {gnt0, gnt1}, 2'b00);
    chk("ab_data0", data0, '0);
    chk("ab_maddr", mem_addr, '0);
    chk("ab_mext",  mem_extra, '0);
    reset = 1'b0;
    tick();
    chk("ab_regnt", {gnt0, gnt1}, 2'b10);
    tick();
    chk("ab_noval", valid0, 1'b0);
    tick();
    chk("ab_val0",  valid0, 1'b1);
    chk("ab_byte",  data0[7:0], 8'h2A);
    req0 = 1'b0;
    tick();

    // Request dropped right after grant still completes
    req0 = 1'b1; addr0 = 5'd10; extra0 = 4'd2;
    tick();
    chk("dr_gnt0",  gnt0, 1'b1);
    req0 = 1'b0;
    tick();
    chk("dr_wait",  valid0, 1'b0);
    tick();
    chk("dr_val0",  valid0, 1'b1);
    chk("dr_byte",  data0[7:0], 8'h23);
    chk("dr_err",   error0, 1'b0);
    tick();
    chk("dr_idle",  {gnt0, gnt1, valid0, valid1}, 4'b0000);
    tick();
    chk("dr_nognt", {gnt0, gnt1}, 2'b00);
    chk("dr_maddr", mem_addr, 5'd10);
    chk("dr_mext",  mem_extra, 4'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
